// File: rtl/cic_interpolator_mc_if.sv
// cic_interpolator_mc_if: stream and control bundle for cic_interpolator_mc.
// The input stream, the output stream and the rate request travel together.
// The design uses the slave view and its environment uses the master view.
// Defining CIC_INTERPOLATOR_TLAST_EN adds output_tlast to the bundle.
interface cic_interpolator_mc_if #(
  parameter int WIDTH     = 16,
  parameter int REG_WIDTH = 18,
  parameter int IDW       = 1,
  parameter int RW        = 3
);
  logic [WIDTH-1:0]     input_tdata;
  logic                 input_tvalid;
  logic                 input_tready;
  logic [REG_WIDTH-1:0] output_tdata;
  logic [IDW-1:0]       output_tid;
  logic                 output_tvalid;
  logic                 output_tready;
  logic [RW-1:0]        rate;
`ifdef CIC_INTERPOLATOR_TLAST_EN
  logic                 output_tlast;

  modport slave (
    input  input_tdata, input_tvalid, output_tready, rate,
    output input_tready, output_tdata, output_tid, output_tvalid, output_tlast
  );

  modport master (
    output input_tdata, input_tvalid, output_tready, rate,
    input  input_tready, output_tdata, output_tid, output_tvalid, output_tlast
  );
`else
  modport slave (
    input  input_tdata, input_tvalid, output_tready, rate,
    output input_tready, output_tdata, output_tid, output_tvalid
  );

  modport master (
    output input_tdata, input_tvalid, output_tready, rate,
    input  input_tready, output_tdata, output_tid, output_tvalid
  );
`endif
endinterface

// File: rtl/cic_interpolator_mc.sv
// cic_interpolator_mc: multi-channel, runtime-rate CIC interpolator.
// CHANNELS channels share one N-stage comb/integrator datapath.
// Per-channel comb delay lines and integrators are held in register arrays,
// and these arrays are indexed by the current channel counter.
// Each input frame of CHANNELS words produces r*CHANNELS output words.
// The outputs are ordered by cycle first and by channel second.
// Defining CIC_INTERPOLATOR_TLAST_EN adds output_tlast. That signal marks
// the last channel of each output group.
module cic_interpolator_mc #(
  parameter int WIDTH     = 16,
  parameter int RMAX      = 4,
  parameter int M         = 1,
  parameter int N         = 2,
  parameter int CHANNELS  = 2,
  parameter int REG_WIDTH = WIDTH + ((N > $clog2(((RMAX*M)**N)/RMAX)) ? N : $clog2(((RMAX*M)**N)/RMAX)),
  parameter int IDW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic clk,
  input logic rst,
  cic_interpolator_mc_if.slave bus
);

  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0]  RMAX_R  = RW'(RMAX);
  localparam logic [IDW-1:0] LAST_CH = IDW'(CHANNELS - 1);

  // Per-channel filter state
  logic [REG_WIDTH-1:0] combDelay_q [CHANNELS][N][M];
  logic [REG_WIDTH-1:0] integ_q     [CHANNELS][N];

  // Sequencing state
  logic [IDW-1:0]       channel_q;
  logic [RW-1:0]        cycle_q;
  logic [RW-1:0]        rate_q;

  // Registered output word
  logic                 outValid_q;
  logic [REG_WIDTH-1:0] outData_q;
  logic [IDW-1:0]       outTid_q;
`ifdef CIC_INTERPOLATOR_TLAST_EN
  logic                 outLast_q;
`endif

  // Next-state and datapath signals
  logic                 advance;
  logic                 inXfer;
  logic                 step;
  logic                 frameStart;
  logic                 lastCh;
  logic [RW-1:0]        rateClamped;
  logic [RW-1:0]        rateEff;
  logic [IDW-1:0]       channel_d;
  logic [RW-1:0]        cycle_d;
  logic [REG_WIDTH-1:0] combDelay_d [N];
  logic [REG_WIDTH-1:0] integ_d     [N];
  logic [REG_WIDTH-1:0] combX;
  logic [REG_WIDTH-1:0] feed;

  assign bus.input_tready  = advance && (cycle_q == '0);
  assign bus.output_tvalid = outValid_q;
  assign bus.output_tdata  = outData_q;
  assign bus.output_tid    = outTid_q;
`ifdef CIC_INTERPOLATOR_TLAST_EN
  assign bus.output_tlast  = outLast_q;
`endif

  // Handshake, rate clamping and channel/cycle counter sequencing
  always_comb begin
    advance    = !outValid_q || bus.output_tready;
    inXfer     = bus.input_tvalid && advance && (cycle_q == '0);
    step       = (cycle_q == '0) ? inXfer : advance;
    frameStart = inXfer && (channel_q == '0);

    if (bus.rate == '0) begin
      rateClamped = RW'(1);
    end else if (bus.rate > RMAX_R) begin
      rateClamped = RMAX_R;
    end else begin
      rateClamped = bus.rate;
    end

    rateEff   = frameStart ? rateClamped : rate_q;
    lastCh    = (channel_q == LAST_CH);
    channel_d = lastCh ? '0 : channel_q + IDW'(1);
    cycle_d   = cycle_q;
    if (lastCh) begin
      cycle_d = (cycle_q == rateEff - RW'(1)) ? '0 : cycle_q + RW'(1);
    end
  end

  // Comb chain on the sign-extended input, then integrators fed comb output or zero stuffing
  always_comb begin
    combX = {{(REG_WIDTH-WIDTH){bus.input_tdata[WIDTH-1]}}, bus.input_tdata};
    for (int i = 0; i < N; i++) begin
      combDelay_d[i] = combX;
      combX = combX - combDelay_q[channel_q][i][M-1];
    end
    feed = (cycle_q == '0) ? combX : '0;
    for (int i = 0; i < N; i++) begin
      integ_d[i] = integ_q[channel_q][i] + feed;
      feed = integ_d[i];
    end
  end

  // Counters, latched rate and the registered output word; all hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      channel_q  <= '0;
      cycle_q    <= '0;
      rate_q     <= RW'(1);
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outTid_q   <= '0;
`ifdef CIC_INTERPOLATOR_TLAST_EN
      outLast_q  <= 1'b0;
`endif
    end else if (step) begin
      channel_q  <= channel_d;
      cycle_q    <= cycle_d;
      if (frameStart) begin
        rate_q <= rateClamped;
      end
      outValid_q <= 1'b1;
      outData_q  <= integ_d[N-1];
      outTid_q   <= channel_q;
`ifdef CIC_INTERPOLATOR_TLAST_EN
      outLast_q  <= lastCh;
`endif
    end else if (advance) begin
      outValid_q <= 1'b0;
    end
  end

  // Per-channel filter state update; comb delay lines only move when a real input is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < N; i++) begin
          integ_q[c][i] <= '0;
          for (int k = 0; k < M; k++) begin
            combDelay_q[c][i][k] <= '0;
          end
        end
      end
    end else if (step) begin
      for (int i = 0; i < N; i++) begin
        integ_q[channel_q][i] <= integ_d[i];
      end
      if (cycle_q == '0) begin
        for (int i = 0; i < N; i++) begin
          combDelay_q[channel_q][i][0] <= combDelay_d[i];
          for (int k = 1; k < M; k++) begin
            combDelay_q[channel_q][i][k] <= combDelay_q[channel_q][i][k-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator_mc.sv
// tb_cic_interpolator_mc: scoreboard bench for cic_interpolator_mc.
// Defining CIC_INTERPOLATOR_TLAST_EN builds the bench with three channels
// and also checks output_tlast.
`timescale 1ns/1ps
module tb_cic_interpolator_mc;

  localparam int WIDTH  = 16;
  localparam int RMAX   = 4;
  localparam int M      = 1;
  localparam int N      = 2;
`ifdef CIC_INTERPOLATOR_TLAST_EN
  localparam int CHANNELS = 3;
`else
  localparam int CHANNELS = 2;
`endif
  localparam int GROWTH    = $clog2(((RMAX*M)**N)/RMAX);
  localparam int REG_WIDTH = WIDTH + ((N > GROWTH) ? N : GROWTH);
  localparam int IDW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW        = $clog2(RMAX + 1);
  localparam longint MASK  = (longint'(1) << REG_WIDTH) - 1;

  typedef struct packed {
    logic [REG_WIDTH-1:0] data;
    logic [IDW-1:0]       tid;
    logic                 last;
  } exp_t;

  exp_t   expQ[$];
  exp_t   monExp;
  longint xHist[CHANNELS][N*M+1];
  longint acc[CHANNELS][N];
  longint frameVals[CHANNELS];
  int     total = 0;
  int     bad = 0;
  int     seenCount = 0;
  bit     ignoreOut = 0;
  bit     randReady = 0;
  bit     prevStall = 0;
  logic [REG_WIDTH-1:0] prevData;
  logic [IDW-1:0]       prevTid;
  logic                 prevLast;

  logic clk = 0;
  logic rst = 1;

  always #5 clk = ~clk;

  cic_interpolator_mc_if #(.WIDTH(WIDTH), .REG_WIDTH(REG_WIDTH), .IDW(IDW), .RW(RW)) bus ();

  cic_interpolator_mc #(
    .WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N), .CHANNELS(CHANNELS),
    .REG_WIDTH(REG_WIDTH), .IDW(IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic finishBench();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout, required completion", name);
    finishBench();
  endtask

  // Reference model: the N cascaded combs with delay M equal one FIR with
  // binomial taps on the low-rate input. The N integrators are repeated
  // running sums of the zero-stuffed sequence, all taken modulo 2^REG_WIDTH.
  function automatic longint binom(input int n, input int k);
    longint b;
    b = 1;
    for (int j = 0; j < k; j++) b = b * (n - j) / (j + 1);
    return b;
  endfunction

  function automatic int clampRate(input int req);
    if (req == 0) return 1;
    if (req > RMAX) return RMAX;
    return req;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k <= N*M; k++) xHist[c][k] = 0;
      for (int i = 0; i < N; i++) acc[c][i] = 0;
    end
  endtask

  task automatic modelStep(input int ch, input bit hasIn, input longint x, output logic [REG_WIDTH-1:0] y);
    longint c;
    longint f;
    c = 0;
    if (hasIn) begin
      for (int k = N*M; k > 0; k--) xHist[ch][k] = xHist[ch][k-1];
      xHist[ch][0] = x;
      for (int k = 0; k <= N; k++) begin
        c += (((k % 2) == 1) ? -1 : 1) * binom(N, k) * xHist[ch][k*M];
      end
    end
    f = c;
    for (int i = 0; i < N; i++) begin
      acc[ch][i] = (acc[ch][i] + f) & MASK;
      f = acc[ch][i];
    end
    y = REG_WIDTH'(acc[ch][N-1]);
  endtask

  task automatic pushExp(input logic [REG_WIDTH-1:0] d, input int ch);
    exp_t e;
    e.data = d;
    e.tid  = IDW'(ch);
    e.last = (ch == CHANNELS - 1);
    expQ.push_back(e);
  endtask

  task automatic computeFrame(input int r, input bit push);
    logic [REG_WIDTH-1:0] y;
    for (int cyc = 0; cyc < r; cyc++) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        modelStep(ch, cyc == 0, frameVals[ch], y);
        if (push) pushExp(y, ch);
      end
    end
  endtask

  // Drive one input frame. rateReq is presented with word 0 and rateMid with the remaining words.
  task automatic applyStimulus(input int rateReq, input int rateMid, input bit push, input int maxGap);
    computeFrame(clampRate(rateReq), push);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      int gap;
      bit accepted;
      int budget;
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      bus.input_tvalid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      bus.input_tdata  = WIDTH'(frameVals[ch]);
      bus.rate         = RW'((ch == 0) ? rateReq : rateMid);
      bus.input_tvalid = 1'b1;
      accepted = 0;
      budget = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = bus.input_tvalid && bus.input_tready;
        @(posedge clk);
        #1;
        budget++;
        if (!accepted && budget > 1000) timeoutFail("input_handshake");
      end
    end
    bus.input_tvalid = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bus.input_tvalid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    modelReset();
    expQ.delete();
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 5000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput(name, 64'(expQ.size()), 64'(0));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Impulse on channel 0 at rate 4: 1,2,3,4,3,2,1,0 then zeros; other channels stay 0
  task automatic runImpulse(input string name);
    for (int f = 0; f < 3; f++) begin
      for (int cyc = 0; cyc < 4; cyc++) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          int n;
          longint v;
          n = f * 4 + cyc;
          v = (n < 4) ? longint'(n + 1) : ((n < 8) ? longint'(7 - n) : 0);
          pushExp(REG_WIDTH'((ch == 0) ? v : 0), ch);
        end
      end
    end
    for (int f = 0; f < 3; f++) begin
      for (int ch = 0; ch < CHANNELS; ch++) frameVals[ch] = (f == 0 && ch == 0) ? 1 : 0;
      applyStimulus(4, 4, 0, 0);
    end
    waitDrain(name);
  endtask

  // Output monitor and scoreboard, sampling on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid_hold", 64'(bus.output_tvalid), 64'(1));
        checkOutput("stall_data_hold", 64'(bus.output_tdata), 64'(prevData));
        checkOutput("stall_tid_hold", 64'(bus.output_tid), 64'(prevTid));
`ifdef CIC_INTERPOLATOR_TLAST_EN
        checkOutput("stall_tlast_hold", 64'(bus.output_tlast), 64'(prevLast));
`endif
      end
      if (bus.output_tvalid && !bus.output_tready) begin
        checkOutput("stall_input_tready", 64'(bus.input_tready), 64'(0));
      end
      if (bus.output_tvalid && bus.output_tready) begin
        seenCount++;
        if (!ignoreOut) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got data 0x%0h tid %0d, required no output",
                     bus.output_tdata, bus.output_tid);
          end else begin
            monExp = expQ.pop_front();
            checkOutput("out_data", 64'(bus.output_tdata), 64'(monExp.data));
            checkOutput("out_tid", 64'(bus.output_tid), 64'(monExp.tid));
`ifdef CIC_INTERPOLATOR_TLAST_EN
            checkOutput("out_tlast", 64'(bus.output_tlast), 64'(monExp.last));
`endif
          end
        end
      end
      prevStall = bus.output_tvalid && !bus.output_tready;
      prevData  = bus.output_tdata;
      prevTid   = bus.output_tid;
`ifdef CIC_INTERPOLATOR_TLAST_EN
      prevLast  = bus.output_tlast;
`else
      prevLast  = 1'b0;
`endif
    end
  end

  // Downstream ready: held high, or randomly toggled for backpressure
  initial begin
    bus.output_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.output_tready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Global watchdog
  initial begin
    #400000;
    timeoutFail("watchdog");
  end

  // Main sequence
  initial begin
    bus.input_tvalid = 1'b0;
    bus.input_tdata  = '0;
    bus.rate         = '0;
    modelReset();

    applyReset();
    checkOutput("reset_tvalid", 64'(bus.output_tvalid), 64'(0));
    checkOutput("reset_tdata", 64'(bus.output_tdata), 64'(0));
    checkOutput("reset_tid", 64'(bus.output_tid), 64'(0));
    checkOutput("reset_input_tready", 64'(bus.input_tready), 64'(1));
`ifdef CIC_INTERPOLATOR_TLAST_EN
    checkOutput("reset_tlast", 64'(bus.output_tlast), 64'(0));
`endif

    $display("[TB] impulse response at rate 4");
    runImpulse("impulse_drain");

    $display("[TB] channel independence with constant inputs at rate 2");
    applyReset();
    for (int f = 0; f < 4; f++) begin
      for (int cyc = 0; cyc < 2; cyc++) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          longint v;
          v = (ch == 0) ? 100 : ((ch == 1) ? -50 : 30);
          pushExp(REG_WIDTH'((f == 0 && cyc == 0) ? v : 2 * v), ch);
        end
      end
    end
    for (int f = 0; f < 4; f++) begin
      for (int ch = 0; ch < CHANNELS; ch++) frameVals[ch] = (ch == 0) ? 100 : ((ch == 1) ? -50 : 30);
      applyStimulus(2, 2, 0, 1);
    end
    waitDrain("const_drain");

    $display("[TB] rate 0 gives unity pass-through");
    applyReset();
    for (int f = 0; f < 6; f++) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        logic signed [WIDTH-1:0] s;
        s = WIDTH'($urandom);
        frameVals[ch] = s;
        pushExp(REG_WIDTH'(frameVals[ch]), ch);
      end
      applyStimulus(0, int'($urandom_range(0, 7)), 0, 1);
    end
    waitDrain("rate0_drain");

    $display("[TB] reset in the middle of a frame");
    applyReset();
    ignoreOut = 1;
    seenCount = 0;
    for (int ch = 0; ch < CHANNELS; ch++) frameVals[ch] = (ch == 0) ? 1 : 0;
    applyStimulus(4, 4, 0, 0);
    begin
      int budget;
      budget = 0;
      while (seenCount < 2 * CHANNELS + 1) begin
        @(negedge clk);
        #1;
        budget++;
        if (budget > 1000) timeoutFail("midframe_wait");
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_tvalid", 64'(bus.output_tvalid), 64'(0));
    checkOutput("midreset_input_tready", 64'(bus.input_tready), 64'(1));
    rst = 1'b0;
    modelReset();
    expQ.delete();
    ignoreOut = 0;
    runImpulse("impulse_after_reset_drain");

    $display("[TB] randomized frames with backpressure and rate changes");
    applyReset();
    randReady = 1;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      logic signed [WIDTH-1:0] s;
      s = WIDTH'($urandom);
      frameVals[ch] = s;
    end
    applyStimulus(2, 4, 1, 0);
    for (int f = 0; f < 40; f++) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        logic signed [WIDTH-1:0] s;
        s = WIDTH'($urandom);
        frameVals[ch] = s;
      end
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1, 2);
    end
    randReady = 0;
    waitDrain("random_drain");

    finishBench();
  end

endmodule
